// File: rtl/fft_peak_finder.sv
// Per-frame spectral peak search over FFT output: |X|^2 pipeline, running max over bins MIN_BIN..N/2-1.
// Optional magnitude floor with peak_none flag enabled by defining PEAK_FLOOR_EN.
module fft_peak_finder #(
  parameter int          N       = 4096,
  parameter int          BIN_W   = $clog2(N),
  parameter int          MIN_BIN = 1,
  parameter logic [31:0] MIN_MAG = 32'd1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             fft_out_valid,
  input  logic             fft_out_last,
  input  logic [31:0]      fft_out_data,
  output logic             fft_out_ready,
  output logic             peak_valid,
  output logic [BIN_W-1:0] peak_bin,
  output logic [31:0]      peak_mag,
  output logic             peak_none,
  output logic             frame_err
);

`ifdef PEAK_FLOOR_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(N - 1);
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(MIN_BIN);

  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

  state_t           state, state_next;
  logic [1:0]       drain_cnt;
  logic [BIN_W-1:0] bin_cnt;
  logic             accept, at_last_bin, good_last, err_pend;

  logic signed [31:0] re_x, im_x;
  logic               s1_valid, s2_valid;
  logic [BIN_W-1:0]   s1_bin, s2_bin;
  logic [31:0]        s1_re_sq, s1_im_sq, s2_mag;

  logic [31:0]      max_mag, base_mag;
  logic [BIN_W-1:0] max_bin, base_bin;
  logic             in_window;

  assign fft_out_ready = (state == ACCUM);
  assign accept        = fft_out_valid && fft_out_ready;
  assign at_last_bin   = (bin_cnt == LAST_BIN);
  assign good_last     = accept && fft_out_last && at_last_bin;
  assign re_x          = 32'(signed'(fft_out_data[15:0]));
  assign im_x          = 32'(signed'(fft_out_data[31:16]));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ACCUM;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (good_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_next = REPORT;
      REPORT:  state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // A length mismatch is any accepted beat where "last" and "counter at N-1" disagree.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_cnt   <= '0;
      err_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      err_pend  <= accept && (fft_out_last != at_last_bin);
      frame_err <= err_pend;
      if (accept) bin_cnt <= (fft_out_last || at_last_bin) ? '0 : bin_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_mag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bin   <= bin_cnt;
        s1_re_sq <= 32'(re_x * re_x);
        s1_im_sq <= 32'(im_x * im_x);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin <= s1_bin;
        s2_mag <= s1_re_sq + s1_im_sq;
      end
    end
  end

  // Bin 0 reaching the compare stage marks a new frame, so the max restarts there;
  // this also discards anything left over from an aborted frame.
  always_comb begin
    in_window = (s2_bin >= FIRST_BIN) && !s2_bin[BIN_W-1];
    base_mag  = max_mag;
    base_bin  = max_bin;
    if (s2_bin == '0) begin
      base_mag = '0;
      base_bin = FIRST_BIN;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      max_mag <= '0;
      max_bin <= '0;
    end else if (s2_valid) begin
      if (in_window && (s2_mag > base_mag)) begin
        max_mag <= s2_mag;
        max_bin <= s2_bin;
      end else begin
        max_mag <= base_mag;
        max_bin <= base_bin;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_none  <= 1'b0;
    end else begin
      peak_valid <= (state == REPORT);
      if (state == REPORT) begin
        if (FLOOR_EN && (max_mag < MIN_MAG)) begin
          peak_none <= 1'b1;
          peak_bin  <= '0;
          peak_mag  <= '0;
        end else begin
          peak_none <= 1'b0;
          peak_bin  <= max_bin;
          peak_mag  <= max_mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Scoreboard bench for fft_peak_finder: frame expectations are queued at drive time, popped on reports.
// Expectations follow PEAK_FLOOR_EN when it is defined for the build.
module tb_fft_peak_finder;
  localparam int          N       = 4096;
  localparam int          BIN_W   = 12;
  localparam int          MIN_BIN = 1;
  localparam logic [31:0] MIN_MAG = 32'd1024;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             fft_out_valid = 1'b0;
  logic             fft_out_last = 1'b0;
  logic [31:0]      fft_out_data = '0;
  logic             fft_out_ready;
  logic             peak_valid;
  logic [BIN_W-1:0] peak_bin;
  logic [31:0]      peak_mag;
  logic             peak_none;
  logic             frame_err;

  fft_peak_finder #(.N(N), .BIN_W(BIN_W), .MIN_BIN(MIN_BIN), .MIN_MAG(MIN_MAG)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .fft_out_valid(fft_out_valid), .fft_out_last(fft_out_last), .fft_out_data(fft_out_data),
    .fft_out_ready(fft_out_ready), .peak_valid(peak_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .peak_none(peak_none), .frame_err(frame_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          err;
    logic [11:0] bin;
    logic [31:0] mag;
    bit          none;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [N];
  int          checks = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic set_bin(input int b, input logic signed [15:0] re, input logic signed [15:0] im);
    mem[b] = {im, re};
  endtask

  function automatic exp_t model_peak();
    exp_t   e;
    longint best, m, re, im;
    int     best_bin;
    best = 0;
    best_bin = MIN_BIN;
    for (int b = MIN_BIN; b < N / 2; b++) begin
      re = longint'($signed(mem[b][15:0]));
      im = longint'($signed(mem[b][31:16]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        best_bin = b;
      end
    end
    e.err  = 1'b0;
    e.none = 1'b0;
    e.bin  = 12'(best_bin);
    e.mag  = 32'(best);
`ifdef PEAK_FLOOR_EN
    if (best < longint'(MIN_MAG)) begin
      e.none = 1'b1;
      e.bin  = '0;
      e.mag  = '0;
    end
`endif
    return e;
  endfunction

  // Sends len beats from mem; a well-formed frame has len==N with last on its final beat.
  task automatic send_frame(input int len, input int gap, input bit with_last, input bit bad);
    exp_t e;
    int   t;
    if (bad) begin
      e.err = 1'b1; e.bin = '0; e.mag = '0; e.none = 1'b0;
    end else begin
      e = model_peak();
    end
    sb.push_back(e);
    for (int i = 0; i < len; i++) begin
      t = 0;
      while (!fft_out_ready && t < 100) begin
        @(posedge clk_in); #1;
        t++;
      end
      if (t >= 100) check_eq("ready_timeout", 0, 1);
      fft_out_valid = 1'b1;
      fft_out_data  = mem[i];
      fft_out_last  = with_last && (i == len - 1);
      @(posedge clk_in); #1;
      fft_out_valid = 1'b0;
      fft_out_data  = 32'hdead_beef;
      if (i != len - 1) begin
        fft_out_last = (gap > 0);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk_in); #1;
        end
      end
      fft_out_last = 1'b0;
    end
    if (bad) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk_in);
        check_eq($sformatf("err_pulse_c%0d", j), frame_err, j == 1);
        check_eq($sformatf("err_ready_c%0d", j), fft_out_ready, 1);
        check_eq($sformatf("err_nopeak_c%0d", j), peak_valid, 0);
      end
    end else begin
      for (int j = 0; j < 6; j++) begin
        @(negedge clk_in);
        check_eq($sformatf("lat_ready_c%0d", j), fft_out_ready, j >= 4);
        check_eq($sformatf("lat_valid_c%0d", j), peak_valid, j == 4);
      end
    end
    @(posedge clk_in); #1;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && (peak_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_report", {peak_valid, frame_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("report_kind", frame_err, e.err);
        if (!e.err) begin
          check_eq("peak_bin", peak_bin, e.bin);
          check_eq("peak_mag", peak_mag, e.mag);
          check_eq("peak_none", peak_none, e.none);
        end
      end
    end
  end

  initial begin
    #200000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_eq("rst_ready", fft_out_ready, 1);
    check_eq("rst_outs", {peak_valid, peak_bin, peak_mag, peak_none, frame_err}, 0);
    #13 rst_in = 1'b0;
    @(posedge clk_in); #1;

    // single tone
    clear_mem();
    set_bin(100, 16'sd1000, 16'sd0);
    send_frame(N, 0, 1, 0);
    check_eq("tone_hold_bin", peak_bin, 100);
    check_eq("tone_hold_mag", peak_mag, 1000000);

    // tie keeps lower bin; DC and upper half ignored
    clear_mem();
    set_bin(5, 16'sd300, 16'sd400);
    set_bin(9, 16'sd300, 16'sd400);
    set_bin(0, 16'sd32767, 16'sd0);
    set_bin(3000, 16'sd20000, 16'sd0);
    send_frame(N, 0, 1, 0);

    // extreme magnitude
    clear_mem();
    set_bin(7, -16'sd32768, -16'sd32768);
    send_frame(N, 0, 1, 0);

    // short frame, then recovery
    clear_mem();
    set_bin(50, 16'sd2000, 16'sd0);
    send_frame(101, 0, 1, 1);
    clear_mem();
    set_bin(20, 16'sd500, 16'sd0);
    send_frame(N, 0, 1, 0);

    // N beats without last, then recovery
    clear_mem();
    set_bin(30, 16'sd3000, 16'sd0);
    send_frame(N, 0, 0, 1);
    clear_mem();
    set_bin(20, 16'sd500, 16'sd0);
    send_frame(N, 0, 1, 0);

    // gapped stream with stray last on idle cycles
    clear_mem();
    set_bin(100, 16'sd1000, 16'sd0);
    send_frame(N, 2, 1, 0);

    // below-floor maximum
    clear_mem();
    set_bin(50, 16'sd30, 16'sd0);
    send_frame(N, 0, 1, 0);

    // reset mid-frame: partial frame abandoned, outputs cleared immediately
    clear_mem();
    set_bin(10, 16'sd9000, 16'sd0);
    for (int i = 0; i < 200; i++) begin
      fft_out_valid = 1'b1;
      fft_out_data  = mem[i];
      @(posedge clk_in); #1;
    end
    fft_out_valid = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    check_eq("midrst_ready", fft_out_ready, 1);
    check_eq("midrst_outs", {peak_valid, peak_bin, peak_mag, peak_none, frame_err}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    clear_mem();
    set_bin(33, 16'sd100, 16'sd100);
    send_frame(N, 0, 1, 0);

    repeat (10) @(posedge clk_in);
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
